// File: rtl/sample_logger_if.sv
// Sample input, logger control and status signals of sample_logger.
// master drives the sample/control side; slave is the logger.
interface sample_logger_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [4:0]        sample_channel;
  logic [4:0]        chan_sel;
  logic              mode;
  logic              rd_step;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CntW-1:0]   count;
  logic              state;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
  logic [7:0]        drop_cnt;
  logic              tick_toggle;

  modport master (
    output sample_valid, sample_data, sample_channel, chan_sel, mode, rd_step,
    input  rd_data, rd_valid, count, state, full, empty, min_val, max_val, drop_cnt,
           tick_toggle
  );

  modport slave (
    input  sample_valid, sample_data, sample_channel, chan_sel, mode, rd_step,
    output rd_data, rd_valid, count, state, full, empty, min_val, max_val, drop_cnt,
           tick_toggle
  );
endinterface

// File: rtl/sample_logger.sv
// Periodic single-channel ADC logger: offset-corrected samples are written to a ring buffer
// on each tick and popped one at a time on rising edges of a slow rd_step input.
module sample_logger #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned FILL_LEVEL = 30,
  parameter int unsigned OFFSET     = 3431,
  parameter int unsigned DIV        = 5000000
) (
  input  logic           clock_in,
  input  logic           reset_n,
  sample_logger_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned TickW = $clog2(DIV);

  localparam logic [DATA_W-1:0] OffsetW  = DATA_W'(OFFSET);
  localparam logic [CntW-1:0]   DepthC   = CntW'(DEPTH);
  localparam logic [CntW-1:0]   FillC    = CntW'(FILL_LEVEL);
  localparam logic [TickW-1:0]  TickLast = TickW'(DIV - 1);

  localparam logic StFill  = 1'b0;
  localparam logic StDrain = 1'b1;

  logic              rd_s1_q, rd_s2_q, rd_prev_q;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              held_ok_q, held_ok_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic              toggle_q;
  logic              mode_q;
  logic              state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [7:0]        drop_q, drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic tick, wr_req, pop_req, mode_chg, full, empty;
  logic wr_acc, pop_acc, overwrite;

  assign tick     = (tick_cnt_q == TickLast);
  assign wr_req   = tick & held_ok_q;
  assign pop_req  = rd_s2_q & ~rd_prev_q;
  assign mode_chg = (bus.mode != mode_q);
  assign full     = (count_q == DepthC);
  assign empty    = (count_q == '0);

  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

  // A write on the capture cycle still sees the previous hold value.
  always_comb begin
    hold_d    = hold_q;
    held_ok_d = held_ok_q;
    if (bus.sample_valid && (bus.sample_channel == bus.chan_sel)) begin
      hold_d    = (bus.sample_data < OffsetW) ? '0 : bus.sample_data - OffsetW;
      held_ok_d = 1'b1;
    end
  end

  always_comb begin
    wr_acc  = 1'b0;
    pop_acc = 1'b0;
    state_d = state_q;
    if (mode_chg) begin
      state_d = StFill;
    end else if (bus.mode) begin
      wr_acc  = wr_req;
      pop_acc = pop_req & ~empty;
      state_d = StFill;
    end else if (state_q == StFill) begin
      wr_acc = wr_req & ~full;
      if (count_q >= FillC) state_d = StDrain;
    end else begin
      pop_acc = pop_req & ~empty;
      if (empty) state_d = StFill;
    end
  end

  assign overwrite = wr_acc & full & ~pop_acc;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (mode_chg) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_acc || overwrite) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (overwrite) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else if (wr_acc && !pop_acc) begin
        count_d = count_q + CntW'(1);
      end else if (pop_acc && !wr_acc) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_comb begin
    min_d     = min_q;
    max_d     = max_q;
    rd_data_d = rd_data_q;
    if (wr_acc) begin
      if (hold_q < min_q) min_d = hold_q;
      if (hold_q > max_q) max_d = hold_q;
    end
    // Reading before the same-edge write keeps a full-buffer pop on the oldest entry.
    if (pop_acc) rd_data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      rd_prev_q  <= 1'b0;
      hold_q     <= '0;
      held_ok_q  <= 1'b0;
      tick_cnt_q <= '0;
      toggle_q   <= 1'b0;
      // Track the live mode so leaving reset never looks like a mode change.
      mode_q     <= bus.mode;
      state_q    <= StFill;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      min_q      <= '1;
      max_q      <= '0;
      drop_q     <= '0;
    end else begin
      rd_s1_q    <= bus.rd_step;
      rd_s2_q    <= rd_s1_q;
      rd_prev_q  <= rd_s2_q;
      hold_q     <= hold_d;
      held_ok_q  <= held_ok_d;
      tick_cnt_q <= tick_cnt_d;
      toggle_q   <= toggle_q ^ tick;
      mode_q     <= bus.mode;
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= pop_acc;
      min_q      <= min_d;
      max_q      <= max_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_n && wr_acc) mem_q[wr_ptr_q] <= hold_q;
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.count       = count_q;
  assign bus.state       = state_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.min_val     = min_q;
  assign bus.max_val     = max_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.tick_toggle = toggle_q;
endmodule

// File: tb/tb_sample_logger.sv
// Bench for sample_logger: directed scenarios plus random traffic against a queue-based
// reference model; popped values are checked through a scoreboard.
module tb_sample_logger;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned FILL_LEVEL = 6;
  localparam int unsigned OFFSET     = 3431;
  localparam int unsigned DIV        = 4;
  localparam int          MaxCode    = (1 << DATA_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_logger_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sample_logger #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .FILL_LEVEL(FILL_LEVEL),
    .OFFSET    (OFFSET),
    .DIV       (DIV)
  ) dut (
    .clock_in(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int sb[$];

  // Reference model state: the buffer is a plain queue, oldest entry at the front.
  int m_q[$];
  int m_j, m_hold, m_min, m_max, m_drop, m_rd_data;
  bit m_state, m_mode_prev, m_held, m_toggle, m_rd_valid;
  bit h1, h2, h3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_push(input int v);
    m_q.push_back(v);
    if (v < m_min) m_min = v;
    if (v > m_max) m_max = v;
  endfunction

  function automatic void m_pop();
    m_rd_data  = m_q.pop_front();
    m_rd_valid = 1'b1;
    sb.push_back(m_rd_data);
  endfunction

  always @(posedge clk) begin
    bit tick, wr, pop;
    int wval, n0, d;
    if (!rst_n) begin
      m_q.delete();
      m_j = 0; m_hold = 0; m_held = 0; m_toggle = 0; m_state = 0;
      m_mode_prev = bus.mode; m_rd_valid = 0; m_rd_data = 0;
      m_min = MaxCode; m_max = 0; m_drop = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      m_j++;
      tick = (m_j % DIV) == 0;
      wr   = tick && m_held;
      wval = m_hold;
      pop  = h2 && !h3;
      h3 = h2; h2 = h1; h1 = bus.rd_step;
      n0 = m_q.size();
      m_rd_valid = 0;
      if (bus.mode != m_mode_prev) begin
        m_q.delete();
        m_state = 0;
      end else if (bus.mode) begin
        if (pop && n0 > 0) m_pop();
        if (wr) begin
          if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            if (m_drop < 255) m_drop++;
          end
          m_push(wval);
        end
      end else if (!m_state) begin
        if (wr && n0 < DEPTH) m_push(wval);
        if (n0 >= FILL_LEVEL) m_state = 1;
      end else begin
        if (pop && n0 > 0) m_pop();
        if (n0 == 0) m_state = 0;
      end
      m_mode_prev = bus.mode;
      if (tick) m_toggle = !m_toggle;
      if (bus.sample_valid && bus.sample_channel == bus.chan_sel) begin
        d      = int'(bus.sample_data);
        m_hold = (d >= OFFSET) ? d - OFFSET : 0;
        m_held = 1;
      end
    end
    #1;
    chk("count", 32'(bus.count), 32'(m_q.size()));
    chk("state", 32'(bus.state), 32'(m_state));
    chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
    chk("min_val", 32'(bus.min_val), m_min);
    chk("max_val", 32'(bus.max_val), m_max);
    chk("drop_cnt", 32'(bus.drop_cnt), m_drop);
    chk("tick_toggle", 32'(bus.tick_toggle), 32'(m_toggle));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
    chk("rd_data", 32'(bus.rd_data), m_rd_data);
  end

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 rd_data=%0d, expected no pop", bus.rd_data);
      end else begin
        chk("rd_data_sb", 32'(bus.rd_data), sb.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  // Capture a sample on the edge just before a tick so that tick writes it exactly once.
  task automatic tick_write(input int raw, input int ch);
    for (int i = 0; i < int'(DIV) && ((m_j + 1) % DIV) != DIV - 1; i++) cyc(1);
    bus.sample_valid   = 1'b1;
    bus.sample_data    = DATA_W'(raw);
    bus.sample_channel = 5'(ch);
    cyc(1);
    bus.sample_valid = 1'b0;
    cyc(1);
  endtask

  task automatic press_chk(input int exp);
    bus.rd_step = 1'b1;
    cyc(4);
    chk("pop_value", 32'(bus.rd_data), exp);
    bus.rd_step = 1'b0;
  endtask

  initial begin
    bus.sample_valid   = 1'b0;
    bus.sample_data    = '0;
    bus.sample_channel = '0;
    bus.chan_sel       = 5'd17;
    bus.mode           = 1'b0;
    bus.rd_step        = 1'b0;
    cyc(2);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_min", 32'(bus.min_val), MaxCode);
    chk("rst_max", 32'(bus.max_val), 0);
    rst_n = 1'b1;

    // Offset subtraction, saturation and channel filtering.
    tick_write(3500, 17);
    chk("cap_count1", 32'(bus.count), 1);
    chk("cap_min1", 32'(bus.min_val), 69);
    chk("cap_max1", 32'(bus.max_val), 69);
    tick_write(3400, 17);
    chk("sat_min", 32'(bus.min_val), 0);
    tick_write(4000, 5);
    chk("chan_filter_max", 32'(bus.max_val), 69);
    chk("chan_filter_cnt", 32'(bus.count), 3);

    // Mode 0 fill then drain.
    do_reset();
    for (int v = 1; v <= 6; v++) tick_write(v + OFFSET, 17);
    chk("fill_count", 32'(bus.count), 6);
    cyc(1);
    chk("fill_to_drain", 32'(bus.state), 1);
    tick_write(7 + OFFSET, 17);
    tick_write(8 + OFFSET, 17);
    chk("drain_no_write", 32'(bus.count), 6);
    chk("drain_no_drop", 32'(bus.drop_cnt), 0);
    for (int v = 1; v <= 5; v++) begin
      press_chk(v);
      cyc(3);
    end
    press_chk(6);
    chk("drain_empty", 32'(bus.count), 0);
    chk("drain_to_fill", 32'(bus.state), 0);
    cyc(3);

    // Mode 1 overwrite when full.
    bus.mode = 1'b1;
    do_reset();
    for (int v = 1; v <= 10; v++) tick_write(v + OFFSET, 17);
    chk("ring_count", 32'(bus.count), 8);
    chk("ring_full", 32'(bus.full), 1);
    chk("ring_drop", 32'(bus.drop_cnt), 2);
    press_chk(3);
    cyc(3);

    // Mode 1 pop coinciding with a tick write.
    do_reset();
    for (int v = 1; v <= 5; v++) tick_write(v + OFFSET, 17);
    cyc(1);
    bus.rd_step = 1'b1;
    cyc(3);
    chk("same_cycle_count", 32'(bus.count), 5);
    chk("same_cycle_rd", 32'(bus.rd_data), 1);
    bus.rd_step = 1'b0;
    cyc(3);

    // Reset in the middle of a drain with rd_step held high.
    bus.mode = 1'b0;
    do_reset();
    for (int v = 1; v <= 6; v++) tick_write(v + OFFSET, 17);
    cyc(1);
    press_chk(1);
    cyc(3);
    press_chk(2);
    cyc(3);
    chk("pre_reset_count", 32'(bus.count), 4);
    bus.rd_step = 1'b1;
    do_reset();
    cyc(4);
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_min", 32'(bus.min_val), MaxCode);
    chk("mid_rst_max", 32'(bus.max_val), 0);
    bus.rd_step = 1'b0;
    cyc(3);

    // Random traffic across both modes, checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      bus.sample_valid   = ($urandom_range(0, 2) == 0);
      bus.sample_data    = DATA_W'($urandom_range(3300, 4095));
      bus.sample_channel = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd17;
      if ($urandom_range(0, 3) == 0) bus.rd_step = ~bus.rd_step;
      if ($urandom_range(0, 199) == 0) bus.mode = ~bus.mode;
      rst_n = ($urandom_range(0, 399) != 0);
      cyc(1);
    end
    rst_n       = 1'b1;
    bus.rd_step = 1'b0;
    cyc(10);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
